// File: rtl/ldq_alloc_ctrl.sv
// rtl/ldq_alloc_ctrl.sv - load-queue allocation, pointer and RAM write-port sequencer (optional LDQ_CTRL_STALE_DROP_EN)
module ldq_alloc_ctrl #(
    parameter int DEPTH = 16,
    parameter int INDEX = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dispValid_i,
    input  logic [WIDTH-1:0] dispData_i,
    output logic             dispReady_o,
    output logic [INDEX-1:0] dispIdx_o,
    input  logic             agenValid_i,
    input  logic [INDEX-1:0] agenIdx_i,
    input  logic [WIDTH-1:0] agenData_i,
    output logic             agenReady_o,
    input  logic             commitValid_i,
    input  logic             flush_i,
    output logic             ramWe_o,
    output logic [INDEX-1:0] ramAddrWr_o,
    output logic [WIDTH-1:0] ramDataWr_o,
    output logic [INDEX-1:0] headIdx_o,
    output logic [INDEX-1:0] tailIdx_o,
    output logic [INDEX:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);

    // Source of the single RAM write this cycle
    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_DISP  = 2'd1,
        SRC_FIFO0 = 2'd2,
        SRC_FIFO1 = 2'd3
    } wr_src_t;

    // Circular queue state
    logic [INDEX-1:0] head;
    logic [INDEX-1:0] tail;
    logic [INDEX:0]   count;

    // Two-entry AGEN update FIFO
    logic [INDEX-1:0] fifo_idx  [2];
    logic [WIDTH-1:0] fifo_data [2];
    logic             fifo_rd;
    logic             fifo_wr;
    logic [1:0]       fifo_cnt;

    // Registered RAM write port
    logic             ram_we;
    logic [INDEX-1:0] ram_addr;
    logic [WIDTH-1:0] ram_data;

    // Per-cycle control
    logic             full;
    logic             empty;
    logic             fifo_full;
    logic             disp_ready;
    logic             disp_fire;
    logic             commit_fire;
    logic             agen_ready;
    logic             agen_push;
    logic             head_ok;
    logic             next_ok;
    logic [INDEX-1:0] head_next;
    logic [1:0]       pop_cnt;
    wr_src_t          wr_src;
    logic             wr_we;
    logic [INDEX-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;

    assign full        = (count == (INDEX+1)'(DEPTH));
    assign empty       = (count == '0);
    assign fifo_full   = (fifo_cnt == 2'd2);
    assign disp_ready  = !full && !fifo_full && !flush_i;
    assign disp_fire   = dispValid_i && disp_ready;
    assign commit_fire = commitValid_i && !empty;
    assign agen_ready  = (fifo_cnt < 2'd2);
    assign agen_push   = agenValid_i && agen_ready && !flush_i;
    assign head_next   = commit_fire ? head + INDEX'(1) : head;

`ifdef LDQ_CTRL_STALE_DROP_EN
    // An entry is live when its distance from head is below the occupancy
    logic [INDEX-1:0] off0;
    logic [INDEX-1:0] off1;

    assign off0    = fifo_idx[fifo_rd] - head;
    assign off1    = fifo_idx[fifo_rd ^ 1'b1] - head;
    assign head_ok = (count != '0) && ({1'b0, off0} < count);
    assign next_ok = (count != '0) && ({1'b0, off1} < count);
`else
    assign head_ok = 1'b1;
    assign next_ok = 1'b1;
`endif

    // Write-port arbitration: full FIFO drains first, then dispatch, then FIFO
    always_comb begin
        wr_src  = SRC_NONE;
        pop_cnt = 2'd0;
        if (flush_i) begin
            wr_src  = SRC_NONE;
            pop_cnt = 2'd0;
        end else if (fifo_full) begin
            if (head_ok) begin
                wr_src  = SRC_FIFO0;
                pop_cnt = 2'd1;
            end else begin
                // Stale head discarded; dispatch is stalled, so the second entry gets the slot
                pop_cnt = 2'd2;
                wr_src  = next_ok ? SRC_FIFO1 : SRC_NONE;
            end
        end else if (disp_fire) begin
            wr_src = SRC_DISP;
        end else if (fifo_cnt != 2'd0) begin
            pop_cnt = 2'd1;
            wr_src  = head_ok ? SRC_FIFO0 : SRC_NONE;
        end
    end

    // Mux the selected source onto the write bus
    always_comb begin
        wr_we   = 1'b0;
        wr_addr = tail;
        wr_data = dispData_i;
        case (wr_src)
            SRC_DISP: begin
                wr_we   = 1'b1;
                wr_addr = tail;
                wr_data = dispData_i;
            end
            SRC_FIFO0: begin
                wr_we   = 1'b1;
                wr_addr = fifo_idx[fifo_rd];
                wr_data = fifo_data[fifo_rd];
            end
            SRC_FIFO1: begin
                wr_we   = 1'b1;
                wr_addr = fifo_idx[fifo_rd ^ 1'b1];
                wr_data = fifo_data[fifo_rd ^ 1'b1];
            end
            default: begin
                wr_we   = 1'b0;
                wr_addr = tail;
                wr_data = dispData_i;
            end
        endcase
    end

    // Head/tail/count update; flush rewinds tail onto the post-commit head
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head <= head_next;
            if (flush_i) begin
                tail  <= head_next;
                count <= '0;
            end else begin
                if (disp_fire) begin
                    tail <= tail + INDEX'(1);
                end
                count <= count + (INDEX+1)'(disp_fire) - (INDEX+1)'(commit_fire);
            end
        end
    end

    // AGEN FIFO: push and pop may coincide; flush empties it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_rd      <= 1'b0;
            fifo_wr      <= 1'b0;
            fifo_cnt     <= 2'd0;
            fifo_idx[0]  <= '0;
            fifo_idx[1]  <= '0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
        end else if (flush_i) begin
            fifo_rd  <= 1'b0;
            fifo_wr  <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (agen_push) begin
                fifo_idx[fifo_wr]  <= agenIdx_i;
                fifo_data[fifo_wr] <= agenData_i;
                fifo_wr            <= fifo_wr ^ 1'b1;
            end
            fifo_rd  <= fifo_rd ^ pop_cnt[0];
            fifo_cnt <= fifo_cnt + {1'b0, agen_push} - pop_cnt;
        end
    end

    // Register the arbitrated write toward the RAM; address/data hold when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
        end else begin
            ram_we <= wr_we;
            if (wr_we) begin
                ram_addr <= wr_addr;
                ram_data <= wr_data;
            end
        end
    end

    assign dispReady_o = disp_ready;
    assign dispIdx_o   = tail;
    assign agenReady_o = agen_ready;
    assign ramWe_o     = ram_we;
    assign ramAddrWr_o = ram_addr;
    assign ramDataWr_o = ram_data;
    assign headIdx_o   = head;
    assign tailIdx_o   = tail;
    assign count_o     = count;
    assign full_o      = full;
    assign empty_o     = empty;

endmodule

// File: tb/tb_ldq_alloc_ctrl.sv
// tb/tb_ldq_alloc_ctrl.sv - directed table-driven bench for ldq_alloc_ctrl
module tb_ldq_alloc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       disp_valid;
    logic [7:0] disp_data;
    logic       disp_ready;
    logic [3:0] disp_idx;
    logic       agen_valid;
    logic [3:0] agen_idx;
    logic [7:0] agen_data;
    logic       agen_ready;
    logic       commit_valid;
    logic       flush;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic [3:0] head_idx;
    logic [3:0] tail_idx;
    logic [4:0] count;
    logic       full;
    logic       empty;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ldq_alloc_ctrl #(.DEPTH(16), .INDEX(4), .WIDTH(8)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .dispValid_i   (disp_valid),
        .dispData_i    (disp_data),
        .dispReady_o   (disp_ready),
        .dispIdx_o     (disp_idx),
        .agenValid_i   (agen_valid),
        .agenIdx_i     (agen_idx),
        .agenData_i    (agen_data),
        .agenReady_o   (agen_ready),
        .commitValid_i (commit_valid),
        .flush_i       (flush),
        .ramWe_o       (ram_we),
        .ramAddrWr_o   (ram_addr),
        .ramDataWr_o   (ram_data),
        .headIdx_o     (head_idx),
        .tailIdx_o     (tail_idx),
        .count_o       (count),
        .full_o        (full),
        .empty_o       (empty)
    );

    typedef struct {
        logic       dv;
        logic [7:0] dd;
        logic       av;
        logic [3:0] ai;
        logic [7:0] ad;
        logic       cv;
        logic       fl;
        logic       e_dr;
        logic [3:0] e_di;
        logic       e_ar;
        logic       e_we;
        logic [3:0] e_wa;
        logic [7:0] e_wd;
        logic [3:0] e_h;
        logic [3:0] e_t;
        logic [4:0] e_c;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(
        input logic dv, input logic [7:0] dd, input logic av, input logic [3:0] ai,
        input logic [7:0] ad, input logic cv, input logic fl,
        input logic e_dr, input logic [3:0] e_di, input logic e_ar,
        input logic e_we, input logic [3:0] e_wa, input logic [7:0] e_wd,
        input logic [3:0] e_h, input logic [3:0] e_t, input logic [4:0] e_c);
        vec_t v;
        v.dv = dv; v.dd = dd; v.av = av; v.ai = ai; v.ad = ad; v.cv = cv; v.fl = fl;
        v.e_dr = e_dr; v.e_di = e_di; v.e_ar = e_ar;
        v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
        v.e_h = e_h; v.e_t = e_t; v.e_c = e_c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [7:0] dd, input logic av,
                         input logic [3:0] ai, input logic [7:0] ad, input logic cv,
                         input logic fl);
        disp_valid   = dv;
        disp_data    = dd;
        agen_valid   = av;
        agen_idx     = ai;
        agen_data    = ad;
        commit_valid = cv;
        flush        = fl;
    endtask

    task automatic step(input logic dv, input logic [7:0] dd, input logic av,
                        input logic [3:0] ai, input logic [7:0] ad, input logic cv);
        @(negedge clk);
        drive(dv, dd, av, ai, ad, cv, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Starting from head = tail = 14, count 0
        tbl[0]  = mk(1, 8'hA0, 0, 0, 8'h00, 0, 0,  1, 14, 1,  1, 14, 8'hA0,  14, 15, 1);
        tbl[1]  = mk(1, 8'hA1, 0, 0, 8'h00, 0, 0,  1, 15, 1,  1, 15, 8'hA1,  14,  0, 2);
        tbl[2]  = mk(1, 8'hA2, 0, 0, 8'h00, 0, 0,  1,  0, 1,  1,  0, 8'hA2,  14,  1, 3);
        tbl[3]  = mk(1, 8'hA3, 0, 0, 8'h00, 0, 0,  1,  1, 1,  1,  1, 8'hA3,  14,  2, 4);
        tbl[4]  = mk(0, 8'h00, 0, 0, 8'h00, 1, 0,  1,  2, 1,  0,  0, 8'h00,  15,  2, 3);
        tbl[5]  = mk(0, 8'h00, 0, 0, 8'h00, 1, 0,  1,  2, 1,  0,  0, 8'h00,   0,  2, 2);
        tbl[6]  = mk(0, 8'h00, 0, 0, 8'h00, 1, 0,  1,  2, 1,  0,  0, 8'h00,   1,  2, 1);
        tbl[7]  = mk(0, 8'h00, 0, 0, 8'h00, 1, 0,  1,  2, 1,  0,  0, 8'h00,   2,  2, 0);
        tbl[8]  = mk(1, 8'hB0, 0, 0, 8'h00, 0, 0,  1,  2, 1,  1,  2, 8'hB0,   2,  3, 1);
        tbl[9]  = mk(1, 8'hB1, 0, 0, 8'h00, 0, 0,  1,  3, 1,  1,  3, 8'hB1,   2,  4, 2);
        tbl[10] = mk(1, 8'hB2, 0, 0, 8'h00, 0, 0,  1,  4, 1,  1,  4, 8'hB2,   2,  5, 3);
        tbl[11] = mk(1, 8'hB3, 0, 0, 8'h00, 0, 0,  1,  5, 1,  1,  5, 8'hB3,   2,  6, 4);
        tbl[12] = mk(1, 8'hB4, 0, 0, 8'h00, 0, 0,  1,  6, 1,  1,  6, 8'hB4,   2,  7, 5);
        // Alloc and commit together at count 5
        tbl[13] = mk(1, 8'hB5, 0, 0, 8'h00, 1, 0,  1,  7, 1,  1,  7, 8'hB5,   3,  8, 5);
        // Continuous dispatch with two AGEN updates to entry 3
        tbl[14] = mk(1, 8'hC0, 1, 3, 8'hE0, 0, 0,  1,  8, 1,  1,  8, 8'hC0,   3,  9, 6);
        tbl[15] = mk(1, 8'hC1, 1, 3, 8'hE1, 0, 0,  1,  9, 1,  1,  9, 8'hC1,   3, 10, 7);
        tbl[16] = mk(1, 8'hC2, 0, 0, 8'h00, 0, 0,  0, 10, 0,  1,  3, 8'hE0,   3, 10, 7);
        tbl[17] = mk(1, 8'hC2, 0, 0, 8'h00, 0, 0,  1, 10, 1,  1, 10, 8'hC2,   3, 11, 8);
        tbl[18] = mk(0, 8'h00, 0, 0, 8'h00, 0, 0,  1, 11, 1,  1,  3, 8'hE1,   3, 11, 8);
        // Flush at count 7 with one queued AGEN entry and commit high
        tbl[19] = mk(0, 8'h00, 0, 0, 8'h00, 1, 0,  1, 11, 1,  0,  0, 8'h00,   4, 11, 7);
        tbl[20] = mk(0, 8'h00, 1, 5, 8'hF0, 0, 0,  1, 11, 1,  0,  0, 8'h00,   4, 11, 7);
        tbl[21] = mk(1, 8'hD0, 1, 6, 8'hF1, 1, 1,  0, 11, 1,  0,  0, 8'h00,   5,  5, 0);
        tbl[22] = mk(0, 8'h00, 0, 0, 8'h00, 0, 0,  1,  5, 1,  0,  0, 8'h00,   5,  5, 0);
        tbl[23] = mk(0, 8'h00, 0, 0, 8'h00, 0, 0,  1,  5, 1,  0,  0, 8'h00,   5,  5, 0);

        rst_n = 1'b0;
        drive(0, 8'h00, 0, 0, 8'h00, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        #1;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_agen_ready", 32'(agen_ready), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_head", 32'(head_idx), 0);
        chk("rst_tail", 32'(tail_idx), 0);
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_data", 32'(ram_data), 0);

        // 16 back-to-back dispatches fill the queue
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1, 8'(8'h40 + i), 0, 0, 8'h00, 0, 0);
            #1;
            chk($sformatf("fill%0d_ready", i), 32'(disp_ready), 1);
            chk($sformatf("fill%0d_idx", i), 32'(disp_idx), 32'(i));
            @(posedge clk);
            #1;
            chk($sformatf("fill%0d_we", i), 32'(ram_we), 1);
            chk($sformatf("fill%0d_addr", i), 32'(ram_addr), 32'(i));
            chk($sformatf("fill%0d_data", i), 32'(ram_data), 32'(8'h40 + i));
            chk($sformatf("fill%0d_count", i), 32'(count), 32'(i + 1));
        end
        chk("full_flag", 32'(full), 1);
        chk("full_empty", 32'(empty), 0);
        @(negedge clk);
        #1;
        chk("full_ready", 32'(disp_ready), 0);
        @(posedge clk);
        #1;
        chk("full_no_write", 32'(ram_we), 0);
        chk("full_count", 32'(count), 16);
        chk("full_tail", 32'(tail_idx), 0);

        // Drain, then walk head/tail to 14
        for (int i = 0; i < 16; i++) step(0, 8'h00, 0, 0, 8'h00, 1);
        chk("drain_count", 32'(count), 0);
        chk("drain_head", 32'(head_idx), 0);
        for (int i = 0; i < 14; i++) begin
            step(1, 8'h00, 0, 0, 8'h00, 0);
            step(0, 8'h00, 0, 0, 8'h00, 1);
        end
        chk("pre_head", 32'(head_idx), 14);
        chk("pre_tail", 32'(tail_idx), 14);

        // Table-driven vectors
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive(tbl[i].dv, tbl[i].dd, tbl[i].av, tbl[i].ai, tbl[i].ad, tbl[i].cv, tbl[i].fl);
            #1;
            chk($sformatf("v%0d_disp_ready", i), 32'(disp_ready), 32'(tbl[i].e_dr));
            chk($sformatf("v%0d_disp_idx", i), 32'(disp_idx), 32'(tbl[i].e_di));
            chk($sformatf("v%0d_agen_ready", i), 32'(agen_ready), 32'(tbl[i].e_ar));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", i), 32'(ram_we), 32'(tbl[i].e_we));
            if (tbl[i].e_we) begin
                chk($sformatf("v%0d_addr", i), 32'(ram_addr), 32'(tbl[i].e_wa));
                chk($sformatf("v%0d_data", i), 32'(ram_data), 32'(tbl[i].e_wd));
            end
            chk($sformatf("v%0d_head", i), 32'(head_idx), 32'(tbl[i].e_h));
            chk($sformatf("v%0d_tail", i), 32'(tail_idx), 32'(tbl[i].e_t));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_c));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].e_c == 5'd16));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].e_c == 5'd0));
        end

        // Asynchronous reset mid-operation with a queued AGEN entry
        step(1, 8'h11, 1, 0, 8'h22, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_count", 32'(count), 0);
        chk("areset_head", 32'(head_idx), 0);
        chk("areset_tail", 32'(tail_idx), 0);
        chk("areset_we", 32'(ram_we), 0);
        chk("areset_agen_ready", 32'(agen_ready), 1);
        chk("areset_empty", 32'(empty), 1);
        @(negedge clk);
        drive(0, 8'h00, 0, 0, 8'h00, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("areset_fifo_lost", 32'(ram_we), 0);

        // Set up head = 4, tail = 6
        for (int i = 0; i < 4; i++) step(1, 8'h00, 0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0, 8'h00, 1);
        for (int i = 0; i < 2; i++) step(1, 8'h00, 0, 0, 8'h00, 0);
        chk("win_head", 32'(head_idx), 4);
        chk("win_tail", 32'(tail_idx), 6);
        chk("win_count", 32'(count), 2);

        // AGEN to entry 9 (outside the window), then to entry 5 (inside)
        step(0, 8'h00, 1, 9, 8'h99, 0);
        chk("agen9_push_we", 32'(ram_we), 0);
        step(0, 8'h00, 0, 0, 8'h00, 0);
`ifdef LDQ_CTRL_STALE_DROP_EN
        chk("agen9_dropped", 32'(ram_we), 0);
`else
        chk("agen9_we", 32'(ram_we), 1);
        chk("agen9_addr", 32'(ram_addr), 9);
        chk("agen9_data", 32'(ram_data), 32'h99);
`endif
        step(0, 8'h00, 1, 5, 8'h55, 0);
        chk("agen5_push_we", 32'(ram_we), 0);
        step(0, 8'h00, 0, 0, 8'h00, 0);
        chk("agen5_we", 32'(ram_we), 1);
        chk("agen5_addr", 32'(ram_addr), 5);
        chk("agen5_data", 32'(ram_data), 32'h55);
        step(0, 8'h00, 0, 0, 8'h00, 0);
        chk("agen_idle_we", 32'(ram_we), 0);
        chk("agen_end_count", 32'(count), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
